// File: rtl/rapid_pkg.sv
// Shared types and constants for the RAPID-X fetch front end.
package rapid_pkg;

  localparam int FETCH_XLEN = 32;

  // Canonical no-op (addi x0, x0, 0) shown to decode when nothing is queued.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] instr;
  } fetch_entry_s;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_WAIT,
    FETCH_DISCARD
  } fetch_state_e;

endpackage

// File: rtl/rapid_sync_fifo.sv
// Generic pointer-based circular FIFO with synchronous clear and level output.
// The head entry is read combinationally so consumers see it with zero latency.
module rapid_sync_fifo #(
  parameter type entry_t = logic [63:0],
  parameter int  DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head_data,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;
  entry_t        mem_q [DEPTH];

  // Next pointers and level; clear wins over push and pop.
  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q != LW'(DEPTH)) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      level_d = level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Entry storage needs no reset: the level tells consumers what is valid.
  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign head_data = mem_q[rd_ptr_q];
  assign level     = level_q;

endmodule

// File: rtl/rapid_fetch_queue.sv
// Instruction-fetch front end: PC generator, single-outstanding memory
// handshake and a prefetch queue feeding decode, with redirect flushing.
module rapid_fetch_queue
  import rapid_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_pc_load,
  input  logic [XLEN-1:0]        i_ext_pc,
  output logic                   o_imem_req,
  output logic [XLEN-1:0]        o_imem_addr,
  input  logic                   i_imem_ready,
  input  logic                   i_imem_valid,
  input  logic [XLEN-1:0]        i_imem_data,
  output logic                   o_valid,
  output logic [XLEN-1:0]        o_pc,
  output logic [XLEN-1:0]        o_instruction,
  input  logic                   i_ready,
  output logic [$clog2(DEPTH):0] o_level
);

  localparam int LW = $clog2(DEPTH) + 1;

  // Same layout as fetch_entry_s, but sized by this instance's XLEN.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q, resp_pc_d;
  logic            fifo_clear, fifo_push, fifo_pop;
  logic            outstanding, slot_free, req;
  logic [LW-1:0]   level;
  entry_t          head, push_entry;

  // A request reserves its queue slot up front, so a response can never overflow.
  assign outstanding = (state_q != FETCH_IDLE);
  assign slot_free   = ({1'b0, level} + {{LW{1'b0}}, outstanding}) < (LW+1)'(DEPTH);
  assign req         = (state_q == FETCH_IDLE) && slot_free && !i_pc_load && !reset;
  assign push_entry  = '{pc: resp_pc_q, instr: i_imem_data};

  // FSM next state, PC bookkeeping and queue control; a redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    fifo_clear = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    if (i_pc_load) begin
      fifo_clear = 1'b1;
      fetch_pc_d = i_ext_pc & ~XLEN'(3);
      if (state_q != FETCH_IDLE) begin
        state_d = i_imem_valid ? FETCH_IDLE : FETCH_DISCARD;
      end
    end else begin
      fifo_pop = o_valid && i_ready;
      case (state_q)
        FETCH_IDLE: begin
          if (req && i_imem_ready) begin
            resp_pc_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + XLEN'(4);
            state_d    = FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (i_imem_valid) begin
            fifo_push = 1'b1;
            state_d   = FETCH_IDLE;
          end
        end
        FETCH_DISCARD: begin
          if (i_imem_valid) begin
            state_d = FETCH_IDLE;
          end
        end
        default: state_d = FETCH_IDLE;
      endcase
    end
  end

  // Fetch FSM and PC registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
    end
  end

  rapid_sync_fifo #(
    .entry_t (entry_t),
    .DEPTH   (DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (fifo_clear),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head_data (head),
    .level     (level)
  );

  assign o_imem_req    = req;
  assign o_imem_addr   = fetch_pc_q;
  assign o_valid       = (level != '0);
  assign o_pc          = o_valid ? head.pc : RESET_PC;
  assign o_instruction = o_valid ? head.instr : XLEN'(NOP_INSTR);
  assign o_level       = level;

endmodule

// File: tb/tb_rapid_fetch_queue.sv
// Self-checking bench for rapid_fetch_queue: a directed vector table, hand-written
// corner sequences and a randomized run checked against a queue-based reference model.
module tb_rapid_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  // Reference-model view of the memory transaction in flight.
  localparam int M_NONE  = 0;
  localparam int M_LIVE  = 1;
  localparam int M_STALE = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_pc_load;
  logic [31:0] i_ext_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ready;
  logic        i_imem_valid;
  logic [31:0] i_imem_data;
  logic        o_valid;
  logic [31:0] o_pc;
  logic [31:0] o_instruction;
  logic        i_ready;
  logic [2:0]  o_level;

  always #5 clk = ~clk;

  rapid_fetch_queue #(
    .XLEN     (32),
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pc_load     (i_pc_load),
    .i_ext_pc      (i_ext_pc),
    .o_imem_req    (o_imem_req),
    .o_imem_addr   (o_imem_addr),
    .i_imem_ready  (i_imem_ready),
    .i_imem_valid  (i_imem_valid),
    .i_imem_data   (i_imem_data),
    .o_valid       (o_valid),
    .o_pc          (o_pc),
    .o_instruction (o_instruction),
    .i_ready       (i_ready),
    .o_level       (o_level)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    bit          pl;
    logic [31:0] ext;
    bit          ir;
    bit          iv;
    logic [31:0] data;
    bit          rdy;
    bit          ereq;
    logic [31:0] eaddr;
    bit          evalid;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] elevel;
  } vec_t;

  int          tests;
  int          fails;
  ent_t        mq[$];
  logic [31:0] m_fpc;
  logic [31:0] m_rpc;
  int          m_st;
  bit          c_load, c_ir, c_iv, c_rdy;
  logic [31:0] c_ext, c_data;
  bit          mem_pending;
  int          mem_wait;
  int          mem_lat;
  vec_t        tbl [8];

  task checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function bit modelReq();
    return (m_st == M_NONE) && (mq.size() < DEPTH) && !c_load;
  endfunction

  function bit memValid();
    return mem_pending && (mem_wait == 0);
  endfunction

  // Compare every DUT output with what the reference model predicts this cycle.
  task checkOutput();
    bit er;
    er = modelReq();
    checkValue("model_req", 32'(o_imem_req), 32'(er));
    if (er) checkValue("model_addr", o_imem_addr, m_fpc);
    checkValue("model_level", 32'(o_level), 32'(mq.size()));
    checkValue("model_valid", 32'(o_valid), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      checkValue("model_pc", o_pc, mq[0].pc);
      checkValue("model_instr", o_instruction, mq[0].instr);
    end else begin
      checkValue("model_instr", o_instruction, NOP);
    end
  endtask

  task applyStimulus(input bit pl, input logic [31:0] ext, input bit ir, input bit iv,
                     input logic [31:0] d, input bit rdy);
    @(negedge clk);
    i_pc_load    = pl;
    i_ext_pc     = ext;
    i_imem_ready = ir;
    i_imem_valid = iv;
    i_imem_data  = d;
    i_ready      = rdy;
    c_load = pl; c_ext = ext; c_ir = ir; c_iv = iv; c_data = d; c_rdy = rdy;
    #1;
    checkOutput();
  endtask

  task drive(input bit pl, input logic [31:0] ext, input bit ir, input bit rdy);
    applyStimulus(pl, ext, ir, memValid(), $urandom, rdy);
  endtask

  // Advance one clock and update the reference model and the memory responder.
  task clockEdge();
    bit er, accept;
    @(posedge clk);
    er     = modelReq();
    accept = er && c_ir;
    if (c_load) begin
      mq.delete();
      m_fpc = c_ext & ~32'd3;
      if (m_st != M_NONE) m_st = c_iv ? M_NONE : M_STALE;
    end else begin
      if (c_rdy && mq.size() != 0) void'(mq.pop_front());
      if (m_st == M_LIVE && c_iv) begin
        mq.push_back('{pc: m_rpc, instr: c_data});
        m_st = M_NONE;
      end else if (m_st == M_STALE && c_iv) begin
        m_st = M_NONE;
      end else if (m_st == M_NONE && accept) begin
        m_rpc = m_fpc;
        m_fpc = m_fpc + 32'd4;
        m_st  = M_LIVE;
      end
    end
    if (c_iv) mem_pending = 1'b0;
    else if (mem_pending && mem_wait > 0) mem_wait--;
    if (accept) begin
      mem_pending = 1'b1;
      mem_wait    = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
    end
  endtask

  task resetDut(input bit keepMem);
    @(negedge clk);
    reset = 1'b1;
    i_pc_load = 0; i_ext_pc = 0; i_imem_ready = 0; i_imem_valid = 0; i_imem_data = 0; i_ready = 0;
    c_load = 0; c_ext = 0; c_ir = 0; c_iv = 0; c_data = 0; c_rdy = 0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkValue("reset_req", 32'(o_imem_req), 32'd0);
    checkValue("reset_valid", 32'(o_valid), 32'd0);
    checkValue("reset_level", 32'(o_level), 32'd0);
    checkValue("reset_instr", o_instruction, NOP);
    checkValue("reset_pc", o_pc, RESET_PC);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mq.delete();
    m_fpc = RESET_PC;
    m_rpc = RESET_PC;
    m_st  = M_NONE;
    if (!keepMem) begin
      mem_pending = 1'b0;
      mem_wait    = 0;
    end
  endtask

  initial begin
    tests = 0; fails = 0;
    mem_pending = 0; mem_wait = 0; mem_lat = 0;
    reset = 1'b1;
    i_pc_load = 0; i_ext_pc = 0; i_imem_ready = 0; i_imem_valid = 0; i_imem_data = 0; i_ready = 0;

    //           pl ext ir iv data          rdy req addr    vld pc     instr         lvl
    tbl[0] = '{0, 0, 1, 0, 32'h0,         1, 1, 32'h0,  0, 32'h0, NOP,          0};
    tbl[1] = '{0, 0, 1, 1, 32'h1111_0000, 1, 0, 32'h0,  0, 32'h0, NOP,          0};
    tbl[2] = '{0, 0, 1, 0, 32'h0,         1, 1, 32'h4,  1, 32'h0, 32'h1111_0000, 1};
    tbl[3] = '{0, 0, 1, 1, 32'h2222_0004, 1, 0, 32'h0,  0, 32'h0, NOP,          0};
    tbl[4] = '{0, 0, 1, 0, 32'h0,         1, 1, 32'h8,  1, 32'h4, 32'h2222_0004, 1};
    tbl[5] = '{0, 0, 1, 1, 32'h3333_0008, 1, 0, 32'h0,  0, 32'h0, NOP,          0};
    tbl[6] = '{0, 0, 0, 0, 32'h0,         1, 1, 32'hC,  1, 32'h8, 32'h3333_0008, 1};
    tbl[7] = '{0, 0, 0, 0, 32'h0,         1, 1, 32'hC,  0, 32'h0, NOP,          0};

    // Zero-latency memory, decode always ready: one word every two cycles.
    resetDut(0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].pl, tbl[i].ext, tbl[i].ir, tbl[i].iv, tbl[i].data, tbl[i].rdy);
      checkValue($sformatf("tbl%0d_req", i), 32'(o_imem_req), 32'(tbl[i].ereq));
      if (tbl[i].ereq) checkValue($sformatf("tbl%0d_addr", i), o_imem_addr, tbl[i].eaddr);
      checkValue($sformatf("tbl%0d_valid", i), 32'(o_valid), 32'(tbl[i].evalid));
      if (tbl[i].evalid) checkValue($sformatf("tbl%0d_pc", i), o_pc, tbl[i].epc);
      checkValue($sformatf("tbl%0d_instr", i), o_instruction, tbl[i].einstr);
      checkValue($sformatf("tbl%0d_level", i), 32'(o_level), tbl[i].elevel);
      clockEdge();
    end

    // Stall decode until the queue fills, then drain in order and resume at 0x10.
    resetDut(0);
    mem_lat = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 1, 0);
      clockEdge();
    end
    drive(0, 0, 1, 0);
    checkValue("full_level", 32'(o_level), 32'd4);
    checkValue("full_req", 32'(o_imem_req), 32'd0);
    clockEdge();
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 1, 1);
      checkValue($sformatf("drain%0d_pc", i), o_pc, 32'(4 * i));
      if (i == 0) checkValue("drain_full_req", 32'(o_imem_req), 32'd0);
      if (i == 1) begin
        checkValue("resume_req", 32'(o_imem_req), 32'd1);
        checkValue("resume_addr", o_imem_addr, 32'h10);
      end
      clockEdge();
    end

    // Redirect while the 0x20 request is outstanding; its late response is dropped.
    resetDut(0);
    mem_lat = 0;
    drive(1, 32'h18, 1, 0);
    clockEdge();
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0);
      clockEdge();
    end
    mem_lat = 2;
    drive(0, 0, 1, 0);
    checkValue("rd_req20", o_imem_addr, 32'h20);
    clockEdge();
    drive(1, 32'h103, 1, 0);
    checkValue("rd_pre_level", 32'(o_level), 32'd2);
    checkValue("rd_cycle_req", 32'(o_imem_req), 32'd0);
    clockEdge();
    drive(0, 0, 1, 0);
    checkValue("rd_flushed_level", 32'(o_level), 32'd0);
    checkValue("rd_discard_req", 32'(o_imem_req), 32'd0);
    clockEdge();
    drive(0, 0, 1, 0);
    checkValue("rd_stale_resp_iv", 32'(i_imem_valid), 32'd1);
    checkValue("rd_stale_req", 32'(o_imem_req), 32'd0);
    clockEdge();
    drive(0, 0, 1, 0);
    checkValue("rd_no_stale_valid", 32'(o_valid), 32'd0);
    checkValue("rd_target_req", 32'(o_imem_req), 32'd1);
    checkValue("rd_target_addr", o_imem_addr, 32'h100);
    clockEdge();

    // Redirect coincident with a response and a pop: nothing pushed or popped.
    resetDut(0);
    mem_lat = 0;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 0);
      clockEdge();
    end
    drive(1, 32'h200, 1, 1);
    checkValue("co_iv", 32'(i_imem_valid), 32'd1);
    checkValue("co_pre_valid", 32'(o_valid), 32'd1);
    checkValue("co_req", 32'(o_imem_req), 32'd0);
    clockEdge();
    drive(0, 0, 0, 1);
    checkValue("co_level", 32'(o_level), 32'd0);
    checkValue("co_next_req", 32'(o_imem_req), 32'd1);
    checkValue("co_next_addr", o_imem_addr, 32'h200);
    clockEdge();

    // Fetch address wraps from the top of the address space to zero.
    resetDut(0);
    mem_lat = 0;
    drive(1, 32'hFFFF_FFFF, 1, 0);
    clockEdge();
    drive(0, 0, 1, 0);
    checkValue("wrap_first_addr", o_imem_addr, 32'hFFFF_FFFC);
    clockEdge();
    drive(0, 0, 1, 0);
    clockEdge();
    drive(0, 0, 1, 0);
    checkValue("wrap_head_pc", o_pc, 32'hFFFF_FFFC);
    checkValue("wrap_next_addr", o_imem_addr, 32'h0000_0000);
    clockEdge();

    // Reset while waiting on memory; the response that arrives afterwards is ignored.
    resetDut(0);
    mem_lat = 0;
    drive(0, 0, 1, 0);
    clockEdge();
    resetDut(1);
    drive(0, 0, 0, 1);
    checkValue("rst_stale_iv", 32'(i_imem_valid), 32'd1);
    checkValue("rst_first_req", 32'(o_imem_req), 32'd1);
    checkValue("rst_first_addr", o_imem_addr, RESET_PC);
    clockEdge();
    drive(0, 0, 0, 1);
    checkValue("rst_no_valid", 32'(o_valid), 32'd0);
    checkValue("rst_level", 32'(o_level), 32'd0);
    clockEdge();

    // Randomized traffic: variable latency, stalls, redirects and spurious responses.
    resetDut(0);
    mem_lat = -1;
    for (int i = 0; i < 3000; i++) begin
      bit pl, ir, iv, rdy;
      pl  = ($urandom_range(0, 99) < 3);
      ir  = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      iv  = memValid() || (!mem_pending && m_st == M_NONE && $urandom_range(0, 19) == 0);
      applyStimulus(pl, $urandom, ir, iv, $urandom, rdy);
      clockEdge();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rapid_fetch_queue.md
Name: rapid_fetch_queue

Overview:
- Parametrised instruction-fetch front end for the RAPID-X core.
- Replaces the fixed single-register fetch unit with:
  - a PC generator;
  - a variable-latency instruction-memory request/response handshake;
  - a DEPTH-entry prefetch queue that presents {pc, instruction} to the decode stage with a valid/ready stall handshake.
- Handles branch redirects from execute: flushes the queue and discards any stale in-flight response.

Parameters:
- XLEN, 32, datapath and address width.
- DEPTH, 4, prefetch queue entries; power of two, at least 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- i_pc_load  in  1  branch/jump redirect from execute stage.
- i_ext_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0).
- o_imem_req  out  1  fetch request valid.
- o_imem_addr  out  XLEN  fetch address (word aligned).
- i_imem_ready  in  1  memory accepts request this cycle.
- i_imem_valid  in  1  response data valid.
- i_imem_data  in  XLEN  response instruction word.
- o_valid  out  1  queue head valid to decode.
- o_pc  out  XLEN  PC of queue head.
- o_instruction  out  XLEN  instruction of queue head; NOP_INSTR when o_valid=0.
- i_ready  in  1  decode accepts head (0 = pipeline stall).
- o_level  out  $clog2(DEPTH)+1  current queue occupancy.

Behaviour:
- Reset state (registered): fetch_pc=RESET_PC; queue empty; FSM=IDLE.
- Reset outputs: o_imem_req=0, o_valid=0, o_level=0, o_instruction=NOP_INSTR, o_pc=RESET_PC.
- At most one outstanding memory request.
- Slot reservation: a request may issue only when o_level + outstanding < DEPTH. A response therefore never overflows the queue.
- FSM IDLE:
  - o_imem_req = (free slot available) && !i_pc_load; o_imem_addr = fetch_pc.
  - On o_imem_req && i_imem_ready: fetch_pc += 4 (wraps modulo 2^XLEN); save the request address as resp_pc; go to WAIT.
- FSM WAIT:
  - o_imem_req=0.
  - On i_imem_valid: push {resp_pc, i_imem_data}; go to IDLE. A new request may issue in the following cycle, so throughput is one word per two cycles for zero-latency memory.
- FSM DISCARD:
  - o_imem_req=0.
  - On i_imem_valid: drop the data and go to IDLE.
- i_imem_valid in IDLE is ignored (spurious response).
- Pop: when o_valid && i_ready, the head advances. o_pc and o_instruction are driven combinationally from the head entry (zero-latency read).
- Push and pop in the same cycle: o_level unchanged; the entry is ordered after the existing entries.
- Empty queue: a response pushed this cycle becomes visible at o_valid next cycle; there is no bypass.
- Redirect (i_pc_load=1) has priority over every other event in that cycle:
  - queue cleared (o_level=0 next cycle);
  - pop and push suppressed;
  - fetch_pc <= {i_ext_pc[XLEN-1:2], 2'b00};
  - FSM: WAIT -> DISCARD; DISCARD stays DISCARD; IDLE stays IDLE;
  - o_imem_req forced 0 in the redirect cycle.
- Redirect in WAIT coincident with i_imem_valid: the response is dropped and the FSM goes to IDLE.
- First request to the new target issues no earlier than the cycle after the redirect.
- Reset asserted mid-transaction: all state returns to reset values; an in-flight response arriving after reset is ignored.

Decomposition:
- rapid_pkg additions:
  - NOP_INSTR = 32'h0000_0013;
  - typedef fetch_entry_s {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;};
  - enum fetch_state_e {FETCH_IDLE, FETCH_WAIT, FETCH_DISCARD}.
- Sub-module rapid_sync_fifo, parametrised by entry type and DEPTH:
  - pointer-based circular buffer with synchronous clear, push, pop and level;
  - reused later by the load/store unit.
- The top level holds the FSM, fetch_pc, resp_pc and the reservation logic.

Test Plan:
- Reset, zero-latency memory (i_imem_ready=1; i_imem_valid one cycle after accept), i_ready=1 -> addresses 0x0, 0x4, 0x8 requested; o_valid shows pc 0x0, 0x4, 0x8 with matching data, one entry every two cycles.
- Hold i_ready=0 with DEPTH=4 -> o_level rises to 4 and o_imem_req stays 0 afterwards; release i_ready -> the four entries drain in order pc 0x0–0xC, then fetch resumes at 0x10.
- Redirect to 0x103 while a request to 0x20 is outstanding (response 3 cycles later) -> queue empties next cycle; the 0x20 data never appears at o_valid; next request address is 0x100.
- Redirect in the same cycle as i_imem_valid and an i_ready pop -> no push and no pop; o_level=0; FSM in IDLE; next request is to the target.
- fetch_pc=0xFFFF_FFFC -> next request address wraps to 0x0000_0000.
- Assert reset while in WAIT, then deliver i_imem_valid -> response ignored; o_valid=0; first request after reset is RESET_PC.
